// File: rtl/hash_tte_bucket_nway.sv
// hash_tte_bucket_nway: N-way set-associative TTE flow hash bucket.
// Each bucket holds WAYS entries {valid, smac, dmac, portmap}. Lookups compare
// (dmac, smac) against every way in parallel, and the lowest-index hit wins.
// Updates insert, replace or delete a flow with a read-modify-write of the bucket.
// Optional macro HASH_TTE_EVICT_EN: when defined, an insert into a full bucket
// evicts the way selected by a round-robin pointer. When it is undefined, such an
// insert gets upd_nak.
module hash_tte_bucket_nway #(
   parameter int ADDR_W  = 12,
   parameter int WAYS    = 2,
   parameter int PORT_W  = 16,
   parameter int ENTRY_W = 97 + PORT_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              se_req,
   input  logic [ADDR_W-1:0] se_hash,
   input  logic [47:0]       se_dmac,
   input  logic [47:0]       se_smac,
   output logic              se_ack,
   output logic              se_nak,
   output logic [PORT_W-1:0] se_result,
   input  logic              upd_req,
   input  logic              upd_del,
   input  logic [ADDR_W-1:0] upd_hash,
   input  logic [47:0]       upd_dmac,
   input  logic [47:0]       upd_smac,
   input  logic [PORT_W-1:0] upd_portmap,
   output logic              upd_ack,
   output logic              upd_nak,
   input  logic              hash_clear,
   output logic              clear_busy
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int WORD_W = WAYS * ENTRY_W;
   localparam int IDX_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int DM_LSB = PORT_W;
   localparam int SM_LSB = PORT_W + 48;
   localparam int V_BIT  = PORT_W + 96;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_RD, S_WAIT, S_CMP, S_RSP, S_WR, S_GAP
   } state_t;

   state_t              state, state_nxt;
   logic                grant_clr, grant_upd, grant_se;
   logic                clear_op;
   logic [ADDR_W-1:0]   clr_addr;

   logic [ADDR_W-1:0]   op_addr;
   logic [47:0]         op_dmac, op_smac;
   logic [PORT_W-1:0]   op_pm;
   logic                op_upd, op_del;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   ram_q, rd_word;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_wdata;

   logic [WAYS-1:0]     v_q, dlo_q, dhi_q, slo_q, shi_q, hit;
   logic                any_hit, any_free;
   logic [IDX_W-1:0]    hit_idx, free_idx, tgt_idx;
   logic [ENTRY_W-1:0]  hit_entry, new_entry;
   logic                wr_ok, upd_ok_q;

`ifdef HASH_TTE_EVICT_EN
   logic [IDX_W-1:0]    rr_ptr;
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state and arbitration. Only IDLE grants, in the order clear > update > lookup.
   always_comb begin
      state_nxt = state;
      grant_clr = 1'b0;
      grant_upd = 1'b0;
      grant_se  = 1'b0;
      case (state)
         S_IDLE: begin
            if (hash_clear || clear_op) begin
               grant_clr = 1'b1;
               state_nxt = S_CLEAR;
            end else if (upd_req) begin
               grant_upd = 1'b1;
               state_nxt = S_RD;
            end else if (se_req) begin
               grant_se  = 1'b1;
               state_nxt = S_RD;
            end
         end
         S_CLEAR: if (clr_addr == '1) state_nxt = S_IDLE;
         S_RD:    state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_CMP;
         S_CMP:   state_nxt = op_upd ? S_WR : S_RSP;
         S_WR:    state_nxt = S_RSP;
         S_RSP:   state_nxt = S_GAP;
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pending-clear flag. Reset sets it, the end of a sweep drops it, and a pulse
   // that arrives outside IDLE is latched here.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                     clear_op <= 1'b1;
      else if (state == S_CLEAR && clr_addr == '1)   clear_op <= 1'b0;
      else if (state != S_IDLE && hash_clear)        clear_op <= 1'b1;
   end

   // Clear sweep address counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                 clr_addr <= '0;
      else if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
      else                       clr_addr <= '0;
   end

   // Capture the granted operation
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_upd  <= 1'b0;
         op_del  <= 1'b0;
         op_addr <= '0;
         op_dmac <= '0;
         op_smac <= '0;
         op_pm   <= '0;
      end else if (grant_upd) begin
         op_upd  <= 1'b1;
         op_del  <= upd_del;
         op_addr <= upd_hash;
         op_dmac <= upd_dmac;
         op_smac <= upd_smac;
         op_pm   <= upd_portmap;
      end else if (grant_se) begin
         op_upd  <= 1'b0;
         op_del  <= 1'b0;
         op_addr <= se_hash;
         op_dmac <= se_dmac;
         op_smac <= se_smac;
      end
   end

   // Single-port bucket RAM with a registered read
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      ram_q <= mem[mem_addr];
   end

   // Second read register, then split 24-bit key compares per way
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_word <= '0;
         v_q     <= '0;
         dlo_q   <= '0;
         dhi_q   <= '0;
         slo_q   <= '0;
         shi_q   <= '0;
      end else begin
         if (state == S_WAIT) rd_word <= ram_q;
         if (state == S_CMP) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               v_q[w]   <= rd_word[w*ENTRY_W + V_BIT];
               dlo_q[w] <= (rd_word[w*ENTRY_W + DM_LSB      +: 24] == op_dmac[23:0]);
               dhi_q[w] <= (rd_word[w*ENTRY_W + DM_LSB + 24 +: 24] == op_dmac[47:24]);
               slo_q[w] <= (rd_word[w*ENTRY_W + SM_LSB      +: 24] == op_smac[23:0]);
               shi_q[w] <= (rd_word[w*ENTRY_W + SM_LSB + 24 +: 24] == op_smac[47:24]);
            end
         end
      end
   end

   // Lowest-index hit and lowest-index free way
   always_comb begin
      hit       = v_q & dlo_q & dhi_q & slo_q & shi_q;
      any_hit   = 1'b0;
      any_free  = 1'b0;
      hit_idx   = '0;
      free_idx  = '0;
      hit_entry = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (hit[w] && !any_hit) begin
            any_hit   = 1'b1;
            hit_idx   = IDX_W'(w);
            hit_entry = rd_word[w*ENTRY_W +: ENTRY_W];
         end
         if (!v_q[w] && !any_free) begin
            any_free = 1'b1;
            free_idx = IDX_W'(w);
         end
      end
   end

   // Update decision plus RAM port muxing. Only the target way changes, and the
   // other ways are written back from the registered read word.
   always_comb begin
      wr_ok     = 1'b0;
      tgt_idx   = hit_idx;
      new_entry = {1'b1, op_smac, op_dmac, op_pm};
      if (op_del) begin
         if (any_hit) begin
            wr_ok     = 1'b1;
            new_entry = {1'b0, hit_entry[ENTRY_W-2:0]};
         end
      end else if (any_hit) begin
         wr_ok     = 1'b1;
         new_entry = {hit_entry[ENTRY_W-1:PORT_W], op_pm};
      end else if (any_free) begin
         wr_ok   = 1'b1;
         tgt_idx = free_idx;
      end else begin
`ifdef HASH_TTE_EVICT_EN
         wr_ok   = 1'b1;
         tgt_idx = rr_ptr;
`endif
      end

      mem_addr  = op_addr;
      mem_we    = 1'b0;
      mem_wdata = rd_word;
      if (state == S_CLEAR) begin
         mem_addr  = clr_addr;
         mem_we    = 1'b1;
         mem_wdata = '0;
      end else if (state == S_WR && wr_ok) begin
         mem_we = 1'b1;
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (IDX_W'(w) == tgt_idx) mem_wdata[w*ENTRY_W +: ENTRY_W] = new_entry;
         end
      end
   end

`ifdef HASH_TTE_EVICT_EN
   // Global eviction pointer. It advances only when a full-bucket insert evicts a way.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr <= '0;
      end else if (state == S_WR && !op_del && !any_hit && !any_free) begin
         rr_ptr <= (rr_ptr == IDX_W'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
      end
   end
`endif

   // Update outcome, held for the response cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              upd_ok_q <= 1'b0;
      else if (state == S_WR) upd_ok_q <= wr_ok;
   end

   // Response pulses. se_result is held until the next lookup response.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         se_ack    <= 1'b0;
         se_nak    <= 1'b0;
         se_result <= '0;
         upd_ack   <= 1'b0;
         upd_nak   <= 1'b0;
      end else begin
         se_ack  <= 1'b0;
         se_nak  <= 1'b0;
         upd_ack <= 1'b0;
         upd_nak <= 1'b0;
         if (state == S_RSP) begin
            if (op_upd) begin
               upd_ack <= upd_ok_q;
               upd_nak <= !upd_ok_q;
            end else begin
               se_ack    <= any_hit;
               se_nak    <= !any_hit;
               se_result <= any_hit ? hit_entry[PORT_W-1:0] : '0;
            end
         end
      end
   end

   // Sweep indicator
   always_comb clear_busy = (state == S_CLEAR);

endmodule

// File: tb/tb_hash_tte_bucket_nway.sv
// Scoreboard bench for hash_tte_bucket_nway. The driver pushes the expected
// responses from a bucket-level reference model. A monitor pops them and checks
// each response's outcome, result and arrival cycle.
module tb_hash_tte_bucket_nway;

   localparam int ADDR_W = 12;
   localparam int WAYS   = 2;
   localparam int PORT_W = 16;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              rstn;
   logic              se_req, upd_req, upd_del, hash_clear;
   logic [ADDR_W-1:0] se_hash, upd_hash;
   logic [47:0]       se_dmac, se_smac, upd_dmac, upd_smac;
   logic [PORT_W-1:0] upd_portmap, se_result;
   logic              se_ack, se_nak, upd_ack, upd_nak, clear_busy;

   hash_tte_bucket_nway #(.ADDR_W(ADDR_W), .WAYS(WAYS), .PORT_W(PORT_W)) dut (
      .clk(clk), .rstn(rstn),
      .se_req(se_req), .se_hash(se_hash), .se_dmac(se_dmac), .se_smac(se_smac),
      .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
      .upd_req(upd_req), .upd_del(upd_del), .upd_hash(upd_hash),
      .upd_dmac(upd_dmac), .upd_smac(upd_smac), .upd_portmap(upd_portmap),
      .upd_ack(upd_ack), .upd_nak(upd_nak),
      .hash_clear(hash_clear), .clear_busy(clear_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      bit                is_upd;
      bit                ok;
      logic [PORT_W-1:0] res;
      int                cyc_exp;
      int                tag;
   } exp_t;
   exp_t sbq[$];
   int   tag_cnt = 0;

   // Reference model: each bucket is an array of ways
   bit                m_v [DEPTH][WAYS];
   logic [47:0]       m_d [DEPTH][WAYS];
   logic [47:0]       m_s [DEPTH][WAYS];
   logic [PORT_W-1:0] m_p [DEPTH][WAYS];
   int                m_rr;

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++)
         for (int w = 0; w < WAYS; w++) m_v[i][w] = 1'b0;
   endfunction

   function automatic bit model_upd(input int h, input bit del, input logic [47:0] d,
                                    input logic [47:0] s, input logic [PORT_W-1:0] pm);
      int hit  = -1;
      int free = -1;
      int tgt  = -1;
      bit ok   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit < 0 && m_v[h][w] && m_d[h][w] == d && m_s[h][w] == s) hit = w;
         if (free < 0 && !m_v[h][w]) free = w;
      end
      if (del) begin
         if (hit >= 0) begin
            m_v[h][hit] = 1'b0;
            ok = 1'b1;
         end
      end else if (hit >= 0) begin
         m_p[h][hit] = pm;
         ok = 1'b1;
      end else begin
         if (free >= 0) tgt = free;
`ifdef HASH_TTE_EVICT_EN
         else begin
            tgt  = m_rr;
            m_rr = (m_rr + 1) % WAYS;
         end
`endif
         if (tgt >= 0) begin
            m_v[h][tgt] = 1'b1;
            m_d[h][tgt] = d;
            m_s[h][tgt] = s;
            m_p[h][tgt] = pm;
            ok = 1'b1;
         end
      end
      return ok;
   endfunction

   function automatic void model_look(input int h, input logic [47:0] d, input logic [47:0] s,
                                      output bit ok, output logic [PORT_W-1:0] pm);
      ok = 1'b0;
      pm = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (m_v[h][w] && m_d[h][w] == d && m_s[h][w] == s) begin
            ok = 1'b1;
            pm = m_p[h][w];
         end
      end
   endfunction

   // Issue one request and hold it until a response or the cycle budget runs out
   task automatic do_op(input bit upd, input bit del, input int h, input logic [47:0] d,
                        input logic [47:0] s, input logic [PORT_W-1:0] pm, input bit inject_clr);
      exp_t e;
      bit   got = 1'b0;
      @(negedge clk);
      e.is_upd = upd;
      e.tag    = tag_cnt++;
      if (upd) begin
         e.ok  = model_upd(h, del, d, s, pm);
         e.res = '0;
      end else begin
         model_look(h, d, s, e.ok, e.res);
      end
      e.cyc_exp = cyc + 1 + (upd ? 5 : 4);
      sbq.push_back(e);
      if (upd) begin
         upd_del = del; upd_hash = ADDR_W'(h); upd_dmac = d; upd_smac = s;
         upd_portmap = pm; upd_req = 1'b1;
      end else begin
         se_hash = ADDR_W'(h); se_dmac = d; se_smac = s; se_req = 1'b1;
      end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (inject_clr && i == 2) hash_clear = 1'b1;
         if (inject_clr && i == 3) hash_clear = 1'b0;
         if (se_ack || se_nak || upd_ack || upd_nak) got = 1'b1;
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL timeout op %0d: got no response, required one within 30 cycles", e.tag);
      end
      se_req  = 1'b0;
      upd_req = 1'b0;
      hash_clear = 1'b0;
      @(negedge clk);
   endtask

   // Measure one clear sweep
   task automatic check_sweep(input int id);
      int n = 0;
      for (int i = 0; i < 20 && !clear_busy; i++) @(negedge clk);
      while (clear_busy && n < 5000) begin
         n++;
         @(negedge clk);
      end
      compared++;
      if (n != DEPTH) begin
         mismatched++;
         $display("FAIL sweep_len[%0d]: got %0d cycles, required %0d", id, n, DEPTH);
      end
   endtask

   // Monitor: pop and compare on every response pulse
   exp_t me;
   always @(negedge clk) begin
      if (rstn === 1'b1 && (se_ack || se_nak || upd_ack || upd_nak)) begin
         if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_rsp: got se_ack=%0b se_nak=%0b upd_ack=%0b upd_nak=%0b, required none",
                     se_ack, se_nak, upd_ack, upd_nak);
         end else begin
            me = sbq.pop_front();
            compared++;
            if (me.is_upd) begin
               if (upd_ack !== me.ok || upd_nak !== !me.ok || se_ack || se_nak) begin
                  mismatched++;
                  $display("FAIL upd_rsp op %0d: got ack=%0b nak=%0b se_ack=%0b se_nak=%0b, required ack=%0b nak=%0b",
                           me.tag, upd_ack, upd_nak, se_ack, se_nak, me.ok, !me.ok);
               end
            end else begin
               if (se_ack !== me.ok || se_nak !== !me.ok || se_result !== me.res || upd_ack || upd_nak) begin
                  mismatched++;
                  $display("FAIL se_rsp op %0d: got ack=%0b nak=%0b result=%h, required ack=%0b nak=%0b result=%h",
                           me.tag, se_ack, se_nak, se_result, me.ok, !me.ok, me.res);
               end
            end
            compared++;
            if (cyc != me.cyc_exp) begin
               mismatched++;
               $display("FAIL latency op %0d: got cycle %0d, required cycle %0d", me.tag, cyc, me.cyc_exp);
            end
         end
      end
   end

   logic [47:0] k1d, k1s, ad, as_, bd, bs, cd, cs;
   logic [47:0] dpool [3];
   logic [47:0] spool [2];
   int          hpool [4];

   initial begin
      k1d = 48'h60beb403060e; k1s = 48'h60beb403644d;
      ad  = 48'h0a0000000001; as_ = 48'h0b0000000001;
      bd  = 48'h0a0000000002; bs  = 48'h0b0000000002;
      cd  = 48'h0a0000000003; cs  = 48'h0b0000000003;
      dpool[0] = 48'h111111111111; dpool[1] = 48'h111111000000; dpool[2] = 48'hffffff111111;
      spool[0] = 48'h222222222222; spool[1] = 48'h222222ffffff;
      hpool[0] = 0; hpool[1] = DEPTH - 1; hpool[2] = 'h74d; hpool[3] = 'h2a5;

      rstn = 1'b0; se_req = 1'b0; upd_req = 1'b0; upd_del = 1'b0; hash_clear = 1'b0;
      se_hash = '0; upd_hash = '0; se_dmac = '0; se_smac = '0;
      upd_dmac = '0; upd_smac = '0; upd_portmap = '0;
      m_rr = 0;
      model_clear();
      repeat (3) @(negedge clk);
      compared++;
      if ({se_ack, se_nak, upd_ack, upd_nak, clear_busy} !== 5'b0 || se_result !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got acks/naks/busy=%b result=%h, required 0/0",
                  {se_ack, se_nak, upd_ack, upd_nak, clear_busy}, se_result);
      end
      rstn = 1'b1;
      check_sweep(0);

      // Basic insert, lookup and replace
      do_op(0, 0, 'h68e, k1d, k1s, '0, 0);
      do_op(1, 0, 'h68e, k1d, k1s, 16'h0002, 0);
      do_op(0, 0, 'h68e, k1d, k1s, '0, 0);
      do_op(0, 0, 'h68e, k1d, 48'h60beb4030000, '0, 0);
      do_op(1, 0, 'h68e, k1d, k1s, 16'h0004, 0);
      do_op(0, 0, 'h68e, k1d, k1s, '0, 0);
      // Full bucket, then delete
      do_op(1, 0, 'h74d, ad, as_, 16'h0011, 0);
      do_op(1, 0, 'h74d, bd, bs, 16'h0022, 0);
      do_op(1, 0, 'h74d, cd, cs, 16'h0033, 0);
      do_op(0, 0, 'h74d, ad, as_, '0, 0);
      do_op(0, 0, 'h74d, bd, bs, '0, 0);
      do_op(0, 0, 'h74d, cd, cs, '0, 0);
      do_op(1, 1, 'h74d, bd, bs, '0, 0);
      do_op(0, 0, 'h74d, bd, bs, '0, 0);
      do_op(1, 1, 'h74d, bd, bs, '0, 0);

      // Random mix over a small key space so buckets fill up
      for (int n = 0; n < 300; n++) begin
         int op = $urandom_range(9, 0);
         int h  = hpool[$urandom_range(3, 0)];
         logic [47:0] d = dpool[$urandom_range(2, 0)];
         logic [47:0] s = spool[$urandom_range(1, 0)];
         logic [PORT_W-1:0] pm = PORT_W'($urandom);
         if (op < 4)      do_op(1, 0, h, d, s, pm, 0);
         else if (op < 6) do_op(1, 1, h, d, s, '0, 0);
         else             do_op(0, 0, h, d, s, '0, 0);
      end

      // Clear request while a lookup sits in CMP
      do_op(1, 0, 'h123, k1d, k1s, 16'h0040, 0);
      do_op(0, 0, 'h123, k1d, k1s, '0, 1);
      check_sweep(1);
      model_clear();
      do_op(0, 0, 'h123, k1d, k1s, '0, 0);
      do_op(0, 0, 'h68e, k1d, k1s, '0, 0);
      do_op(0, 0, 'h74d, ad, as_, '0, 0);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hash_tte_bucket_nway.md
Name: hash_tte_bucket_nway

Overview:
Parametrised successor of the single-entry TTE flow hash bucket. Each bucket index holds WAYS entries, each entry being {valid, smac, dmac, portmap}. Lookups compare the (dmac, smac) key against all ways in parallel. Updates insert, replace or delete a flow inside a bucket, and report "bucket full" instead of silently overwriting. The block sits between the TTE flow-table config path (update/clear) and the frame-forwarding search path (se_*).

Parameters:
ADDR_W, 12, bucket index width; depth = 2**ADDR_W buckets
WAYS, 2, entries per bucket (1..8)
PORT_W, 16, portmap width
ENTRY_W, 97+PORT_W, derived entry width: [PORT_W-1:0] portmap, next 48 dmac, next 48 smac, MSB valid

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
se_req  in  1  lookup request (level); held until se_ack/se_nak
se_hash  in  ADDR_W  lookup bucket index
se_dmac  in  48  lookup destination MAC
se_smac  in  48  lookup source MAC
se_ack  out  1  one-cycle pulse: hit
se_nak  out  1  one-cycle pulse: miss
se_result  out  PORT_W  portmap of hit way; 0 on miss
upd_req  in  1  update request (level); held until upd_ack/upd_nak
upd_del  in  1  with upd_req: 1 = delete flow, 0 = insert/replace
upd_hash  in  ADDR_W  update bucket index
upd_dmac  in  48  update destination MAC
upd_smac  in  48  update source MAC
upd_portmap  in  PORT_W  portmap to store
upd_ack  out  1  one-cycle pulse: update done
upd_nak  out  1  one-cycle pulse: bucket full (insert) or flow absent (delete)
hash_clear  in  1  pulse: request full table clear
clear_busy  out  1  high while clear sweep runs

Behaviour:
- Reset: all outputs 0; state CLEAR pending (clear_op=1). An automatic sweep follows every reset.
- Storage: inferred single-port RAM, 2**ADDR_W x (WAYS*ENTRY_W), 1-cycle read. The read word is registered once more before compare.
- Arbitration in IDLE only: clear (hash_clear or clear_op) > upd_req > se_req. Requests that are not granted stay pending because they are level signals; a hash_clear pulse arriving while not in IDLE is latched into clear_op.
- States: IDLE, CLEAR, RD, WAIT, CMP, RSP, WR, GAP.
- CLEAR: writes all-zero to address 0 through 2**ADDR_W-1, one address per cycle, clear_busy=1. After the last address: clear_op<=0 and return to IDLE. The sweep takes exactly 2**ADDR_W cycles and cannot be interrupted except by reset.
- Lookup (acceptance edge T): address registered at T+1, RAM data at T+2, way-compare registered at T+3, se_ack or se_nak plus se_result at T+4.
  - Hit condition: valid & dmac match & smac match. Each 48-bit compare is split into two 24-bit halves, registered.
  - On multiple hits the lowest-index way wins.
  - GAP: one idle cycle after a response so the requester can drop its req. A new request is not accepted until T+6.
- Update, same RD/WAIT/CMP pipeline; WR decides:
  - Insert: if a valid way matches (dmac, smac), overwrite that way's portmap. Otherwise write the lowest-index invalid way with valid=1. upd_ack is issued the cycle after the write.
  - Insert, no match and no free way: no write; upd_nak (unless the eviction feature is enabled).
  - Delete: if a matching way exists, clear its valid bit and upd_ack. Otherwise upd_nak.
  - A write modifies only the target way; the other ways are rewritten from the registered read word (read-modify-write).
- Ordering: update and lookup never overlap, so a lookup accepted after upd_ack sees the new entry.
- se_result is held until the next lookup response.
- An asynchronous reset mid-operation aborts it, drops pending pulses, and restarts the clear sweep.

Optional Feature:
HASH_TTE_EVICT_EN
- Defined: a full-bucket insert evicts the way selected by a global round-robin pointer (log2 WAYS bits, advanced on each eviction, reset 0), writes the new flow there, and returns upd_ack.
- Undefined: a full-bucket insert returns upd_nak and leaves the bucket unchanged.

Test Plan:
- Reset release -> clear_busy=1 for exactly 4096 cycles (ADDR_W=12). Then every lookup, e.g. hash 0x68E, returns se_nak with se_result=0.
- Insert dmac 60beb403060e, smac 60beb403644d, portmap 0x0002 at hash 0x68E -> upd_ack. A lookup with the same key returns se_ack exactly 4 cycles after acceptance with se_result=0x0002. The same dmac with a different smac -> se_nak.
- Insert the same key again with portmap 0x0004 -> upd_ack; lookup returns 0x0004 and only one way is valid.
- WAYS=2: insert 3 distinct keys at hash 0x74D -> third returns upd_nak and the first two still hit. With HASH_TTE_EVICT_EN: the third returns upd_ack, way 0 is replaced, and the first key misses.
- Delete the second key -> upd_ack and it now misses. Delete it again -> upd_nak.
- hash_clear pulse while a lookup is in CMP -> lookup completes with its response, then a 4096-cycle sweep runs, and all previous entries miss afterwards.
